// File: rtl/idct2d_engine.sv
// idct2d_engine: two-pass separable inverse transform for one N x N block.
//   Pass 1: T[i][j] = sat_IN_W((sum_k src_i[k] * coefA_j[k]) >>> SHIFT1), stored in an
//           internal register buffer that can be read a whole column at a time.
//   Pass 2: Y[i][j] = clamp((sum_k coefB_i[k] * T[k][j]) >>> SHIFT2) to [0, 2^OUT_W-1],
//           streamed out row-major through a valid/ready handshake.
// Optional macro IDCT_ROUND_EN: adds 2^(SHIFT-1) before each shift (round half up).
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start / busy / done   block control; start sampled only in IDLE, done pulses in FIN
//   src_addr / src_data   source row memory, 1-cycle registered read
//   coef_sel / coef_addr / coef_data   coefficient memory (0 = set A, 1 = set B), 1-cycle read
//   out_valid / out_ready / out_row / out_col / out_data   pixel output stream
//   sat_flag              sticky per block: some result saturated or clamped
module idct2d_engine #(
  parameter int N      = 8,
  parameter int IN_W   = 22,
  parameter int COEF_W = 13,
  parameter int SHIFT1 = 8,
  parameter int SHIFT2 = 16,
  parameter int OUT_W  = 8,
  localparam int AW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        src_addr,
  input  logic [N*IN_W-1:0]    src_data,
  output logic                 coef_sel,
  output logic [AW-1:0]        coef_addr,
  input  logic [N*COEF_W-1:0]  coef_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW-1:0]        out_row,
  output logic [AW-1:0]        out_col,
  output logic [OUT_W-1:0]     out_data,
  output logic                 sat_flag
);

  localparam int PW = IN_W + COEF_W;   // product width
  localparam int SW = PW + AW;         // full accumulation width
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic signed [SW-1:0] T_MAX = SW'((64'sd1 <<< (IN_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] T_MIN = -T_MAX - SW'(1);
  localparam logic signed [SW-1:0] Y_MAX = SW'((64'sd1 <<< OUT_W) - 64'sd1);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P1_DRAIN, S_P2, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           i_q, i_d, j_q, j_d;
  logic                    drain_q, drain_d;
  logic                    issued_q, issued_d;   // all pass-2 issues sent
  logic                    v1_q, pass2_1_q;      // stage 1: memory data present
  logic [AW-1:0]           row1_q, col1_q;
  logic                    stall_q;
  logic [N*COEF_W-1:0]     coef_hold_q, coef_use;
  logic                    tw_v_q;
  logic [AW-1:0]           tw_row_q, tw_col_q;
  logic signed [IN_W-1:0]  tw_data_q;
  logic                    ov_q;
  logic [AW-1:0]           orow_q, ocol_q;
  logic [OUT_W-1:0]        odata_q;
  logic                    sat_q;
  logic signed [IN_W-1:0]  t_q [N][N];

  logic                    stall, issue_now, last_xfer;
  logic signed [PW-1:0]    prod [N];
  logic signed [SW-1:0]    sum, sh1, sh2;
  logic                    hi1, lo1, hi2, lo2;
  logic signed [IN_W-1:0]  t_res;
  logic [OUT_W-1:0]        y_res;

  assign stall     = ov_q & ~out_ready;
  assign issue_now = (state_q == S_P1) | ((state_q == S_P2) & ~issued_q);
  assign last_xfer = ov_q & out_ready & (orow_q == LAST) & (ocol_q == LAST);

  // Coefficient memory keeps presenting data for the held issue address during a stall,
  // not for the item parked in stage 1, so stage 1 uses a copy taken on the first stall cycle.
  assign coef_use = stall_q ? coef_hold_q : coef_data;

  // One MAC lane per element; pass 1 reads the source row, pass 2 a buffer column.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mac
      logic signed [IN_W-1:0]   a_s;
      logic signed [COEF_W-1:0] b_s;
      assign a_s = pass2_1_q ? t_q[gi][col1_q] : $signed(src_data[gi*IN_W +: IN_W]);
      assign b_s = $signed(coef_use[gi*COEF_W +: COEF_W]);
      assign prod[gi] = PW'(a_s) * PW'(b_s);
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + SW'(prod[k]);
  end

`ifdef IDCT_ROUND_EN
  localparam logic signed [SW-1:0] RND1 = SW'(64'sd1 <<< (SHIFT1 - 1));
  localparam logic signed [SW-1:0] RND2 = SW'(64'sd1 <<< (SHIFT2 - 1));
  assign sh1 = (sum + RND1) >>> SHIFT1;
  assign sh2 = (sum + RND2) >>> SHIFT2;
`else
  assign sh1 = sum >>> SHIFT1;
  assign sh2 = sum >>> SHIFT2;
`endif

  assign hi1   = sh1 > T_MAX;
  assign lo1   = sh1 < T_MIN;
  assign t_res = hi1 ? T_MAX[IN_W-1:0] : (lo1 ? T_MIN[IN_W-1:0] : sh1[IN_W-1:0]);
  assign hi2   = sh2 > Y_MAX;
  assign lo2   = sh2[SW-1];
  assign y_res = hi2 ? '1 : (lo2 ? '0 : sh2[OUT_W-1:0]);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    drain_d  = drain_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_P1;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_P1: begin
        if (i_q == LAST && j_q == LAST) begin
          state_d = S_P1_DRAIN;
          i_d     = '0;
          j_d     = '0;
          drain_d = 1'b0;
        end else if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_P1_DRAIN: begin
        // two cycles: last product reaches the write register, then the buffer
        drain_d = 1'b1;
        if (drain_q) begin
          state_d  = S_P2;
          issued_d = 1'b0;
        end
      end
      S_P2: begin
        if (!stall && !issued_q) begin
          if (i_q == LAST && j_q == LAST) begin
            issued_d = 1'b1;
          end else if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        if (last_xfer) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      drain_q     <= 1'b0;
      issued_q    <= 1'b0;
      v1_q        <= 1'b0;
      pass2_1_q   <= 1'b0;
      row1_q      <= '0;
      col1_q      <= '0;
      stall_q     <= 1'b0;
      coef_hold_q <= '0;
      tw_v_q      <= 1'b0;
      tw_row_q    <= '0;
      tw_col_q    <= '0;
      tw_data_q   <= '0;
      ov_q        <= 1'b0;
      orow_q      <= '0;
      ocol_q      <= '0;
      odata_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      drain_q  <= drain_d;
      issued_q <= issued_d;
      stall_q  <= stall;
      if (!stall_q) coef_hold_q <= coef_data;
      if (!stall) begin
        v1_q      <= issue_now;
        pass2_1_q <= (state_q == S_P2);
        row1_q    <= i_q;
        col1_q    <= j_q;
        ov_q      <= v1_q & pass2_1_q;
        orow_q    <= row1_q;
        ocol_q    <= col1_q;
        odata_q   <= y_res;
      end
      tw_v_q    <= v1_q & ~pass2_1_q;
      tw_row_q  <= row1_q;
      tw_col_q  <= col1_q;
      tw_data_q <= t_res;
      if (state_q == S_IDLE && start) begin
        sat_q <= 1'b0;
      end else if (v1_q && (pass2_1_q ? (hi2 || lo2) : (hi1 || lo1))) begin
        sat_q <= 1'b1;
      end
    end
  end

  // Transpose buffer: register array, no reset needed (contents don't-care after reset).
  always_ff @(posedge clk) begin
    if (tw_v_q) t_q[tw_row_q][tw_col_q] <= tw_data_q;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign src_addr  = (state_q == S_P1) ? i_q : '0;
  assign coef_sel  = (state_q == S_P2);
  assign coef_addr = (state_q == S_P1) ? j_q : ((state_q == S_P2) ? i_q : '0);
  assign out_valid = ov_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;
  assign out_data  = odata_q;
  assign sat_flag  = sat_q;

endmodule
